// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch path: opcodes, widths, the fetch entry
// record and the fetch state encoding.
package cpu_isa_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode valid/ready channel carrying one {pc, instr} entry.
interface instr_fetch_unit_if;
  import cpu_isa_pkg::*;

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [XLEN-1:0]    if_pc;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a full FIFO may push and pop on the same edge.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];
  assign do_push   = push && (!full || pop) && !flush;
  assign do_pop    = pop && !empty && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_ONE;
      end
      if (do_pop) begin
        head_d = head_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a combinational ROM and
// buffers {pc, instr} for decode. Define IFU_JUMP_PREDECODE_EN to resolve `j` locally.
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  instr_fetch_unit_if.master dec,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, jump_target;
  logic [31:0]     fetch_count_q, fetch_count_d;
  fetch_entry_t    last_q, last_d, head, push_entry;
  logic            fifo_full, fifo_empty, pop, push, can_fetch, is_jump;

  assign pop        = !fifo_empty && dec.if_ready;
  assign push_entry = '{pc: pc_q, instr: imem_instr};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
`ifdef IFU_JUMP_PREDECODE_EN
    is_jump     = (opcode_of(imem_instr) == OPC_J);
    jump_target = {pc_plus4[31:28], imem_instr[25:0], 2'b00};
`else
    is_jump     = 1'b0;
    jump_target = pc_plus4;
`endif
    can_fetch     = (state_q == ST_FETCH) && !redirect_valid && (!fifo_full || pop);
    push          = can_fetch && !is_jump;
    pc_d          = pc_q;
    state_d       = state_q;
    fetch_count_d = fetch_count_q;
    last_d        = last_q;
    // Redirect wins over everything, but a same-edge transfer still belongs to decode.
    if (redirect_valid) begin
      pc_d    = redirect_target & ~32'h3;
      state_d = ST_FETCH;
    end else if (can_fetch) begin
      if (is_jump) begin
        pc_d = jump_target;
        if (jump_target == pc_q) begin
          state_d = ST_HALT;
        end
      end else begin
        pc_d = pc_plus4;
      end
    end
    if (pop) begin
      fetch_count_d = fetch_count_q + 32'd1;
      last_d        = head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      last_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      last_q        <= last_d;
    end
  end

  // With the buffer empty, decode keeps seeing the entry it last consumed.
  assign imem_addr    = pc_q;
  assign fetch_count  = fetch_count_q;
  assign dec.if_valid = !fifo_empty;
  assign dec.if_pc    = fifo_empty ? last_q.pc    : head.pc;
  assign dec.if_instr = fifo_empty ? last_q.instr : head.instr;

`ifdef IFU_JUMP_PREDECODE_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
